// File: rtl/chiplib_muxn_sync.sv
// chiplib_muxn_sync: N-way registered mux with a guarded, handshaked select switch.
// Define CHIPLIB_MUXN_PARITY_EN to add dout_par, the even parity of dout.
`timescale 1ns/1ps
module chiplib_muxn_sync #(
  parameter int N = 4,
  parameter int WIDTH = 8,
  parameter int GUARD = 2,
  parameter int RST_SEL = 0,
  localparam int SELW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*WIDTH-1:0] din,
  input  logic [SELW-1:0]  sel_req,
  input  logic             sel_vld,
  output logic             sel_rdy,
  output logic [SELW-1:0]  sel_cur,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic             busy,
`ifdef CHIPLIB_MUXN_PARITY_EN
  output logic             dout_par,
`endif
  output logic             sel_err
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SWITCH
  } state_t;

  localparam logic [3:0] CNT_INIT =
    (GUARD == 0) ? 4'd0 : 4'(GUARD - 1);
  localparam logic [SELW-1:0] SEL_RST = SELW'(RST_SEL);
  localparam logic [SELW:0] N_LIM = (SELW+1)'(N);
  localparam state_t ENTRY = (GUARD == 0) ? SWITCH : HOLD;

  state_t          state;
  logic [3:0]      cnt;
  logic [SELW-1:0] pend;

  // Padded to a power of two so any select code indexes safely.
  logic [WIDTH-1:0] ch [2**SELW];

  for (genvar k = 0; k < 2**SELW; k++) begin : g_ch
    if (k < N) begin : g_used
      assign ch[k] = din[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign ch[k] = '0;
    end
  end

  logic [WIDTH-1:0] nxt;
  logic             req_bad;
  logic             req_new;

  assign nxt     = ch[sel_cur];
  assign req_bad = {1'b0, sel_req} >= N_LIM;
  assign req_new = sel_req != sel_cur;
  assign sel_rdy = state == IDLE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pend     <= SEL_RST;
      sel_cur  <= SEL_RST;
      dout     <= '0;
      dout_vld <= 1'b0;
      busy     <= 1'b0;
      sel_err  <= 1'b0;
`ifdef CHIPLIB_MUXN_PARITY_EN
      dout_par <= 1'b0;
`endif
    end else begin
      sel_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sel_vld && !req_bad && req_new) begin
            // dout keeps its last value; only the valid flag drops
            pend     <= sel_req;
            dout_vld <= 1'b0;
            busy     <= 1'b1;
            cnt      <= CNT_INIT;
            state    <= ENTRY;
          end else begin
            dout     <= nxt;
            dout_vld <= 1'b1;
            sel_err  <= sel_vld && req_bad;
`ifdef CHIPLIB_MUXN_PARITY_EN
            dout_par <= ^nxt;
`endif
          end
        end
        HOLD: begin
          if (cnt == 4'd0) state <= SWITCH;
          else cnt <= cnt - 4'd1;
        end
        SWITCH: begin
          sel_cur <= pend;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chiplib_muxn_sync.sv
// tb_chiplib_muxn_sync: edge-indexed reference model plus directed vectors.
// N=5 so that an out-of-range select code exists on the 3-bit select bus.
`timescale 1ns/1ps
module tb_chiplib_muxn_sync;

  localparam int N = 5;
  localparam int W = 8;
  localparam int G = 2;
  localparam int SW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N*W-1:0] din;
  logic [SW-1:0] sel_req = '0;
  logic          sel_vld = 1'b0;
  logic          sel_rdy;
  logic [SW-1:0] sel_cur;
  logic [W-1:0]  dout;
  logic          dout_vld;
  logic          busy;
  logic          sel_err;
`ifdef CHIPLIB_MUXN_PARITY_EN
  logic          dout_par;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit run = 1'b0;

  chiplib_muxn_sync #(
    .N(N), .WIDTH(W), .GUARD(G), .RST_SEL(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .sel_req(sel_req),
    .sel_vld(sel_vld),
    .sel_rdy(sel_rdy),
    .sel_cur(sel_cur),
    .dout(dout),
    .dout_vld(dout_vld),
    .busy(busy),
`ifdef CHIPLIB_MUXN_PARITY_EN
    .dout_par(dout_par),
`endif
    .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] chan(int k);
    return din[k*W +: W];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a switch accepted at edge index a freezes the output and
  // lands the new select at edge a+G+1.
  int           e = 0;
  int           acc = 0;
  bit           in_seq = 1'b0;
  logic [SW-1:0] m_cur, m_pend;
  logic [W-1:0] m_dout;
  logic         m_vld, m_busy, m_err;

  task automatic m_reset();
    in_seq = 1'b0;
    m_cur  = '0;
    m_pend = '0;
    m_dout = '0;
    m_vld  = 1'b0;
    m_busy = 1'b0;
    m_err  = 1'b0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_reset();
      end else begin
        m_err = 1'b0;
        if (in_seq) begin
          m_vld = 1'b0;
          if (e == acc + G + 1) begin
            m_cur  = m_pend;
            m_busy = 1'b0;
            in_seq = 1'b0;
          end
        end else if (sel_vld && int'(sel_req) >= N) begin
          m_err  = 1'b1;
          m_dout = chan(int'(m_cur));
          m_vld  = 1'b1;
        end else if (sel_vld && sel_req != m_cur) begin
          in_seq = 1'b1;
          acc    = e;
          m_pend = sel_req;
          m_vld  = 1'b0;
          m_busy = 1'b1;
        end else begin
          m_dout = chan(int'(m_cur));
          m_vld  = 1'b1;
        end
        e++;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (run) begin
      check("rdy", 32'(sel_rdy), 32'(!in_seq));
      check("cur", 32'(sel_cur), 32'(m_cur));
      check("dout", 32'(dout), 32'(m_dout));
      check("vld", 32'(dout_vld), 32'(m_vld));
      check("busy", 32'(busy), 32'(m_busy));
      check("err", 32'(sel_err), 32'(m_err));
`ifdef CHIPLIB_MUXN_PARITY_EN
      check("par", 32'(dout_par), 32'(^m_dout));
`endif
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic req(logic [SW-1:0] s);
    sel_req = s;
    sel_vld = 1'b1;
    tick();
    sel_vld = 1'b0;
  endtask

  initial begin
    din = {8'h3C, 8'h07, 8'hA5, 8'h22, 8'h11};
    tick(2);
    run = 1'b1;
    tick();
    check("lit_rst_dout", 32'(dout), 32'h00);
    check("lit_rst_vld", 32'(dout_vld), 32'h0);
    rst = 1'b0;
    tick();
    check("lit_first_dout", 32'(dout), 32'h11);
    check("lit_first_vld", 32'(dout_vld), 32'h1);
    check("lit_first_cur", 32'(sel_cur), 32'h0);

    // 0 -> 2, with ch0 changing while frozen
    req(3'd2);
    din[7:0] = 8'h5A;
    check("lit_hold_dout", 32'(dout), 32'h11);
    check("lit_hold_vld", 32'(dout_vld), 32'h0);
    check("lit_hold_busy", 32'(busy), 32'h1);
    check("lit_hold_rdy", 32'(sel_rdy), 32'h0);
    tick(2);
    check("lit_sw_busy", 32'(busy), 32'h1);
    tick();
    check("lit_cur2", 32'(sel_cur), 32'h2);
    check("lit_cur2_vld", 32'(dout_vld), 32'h0);
    tick();
    check("lit_new_dout", 32'(dout), 32'hA5);
    check("lit_new_vld", 32'(dout_vld), 32'h1);
`ifdef CHIPLIB_MUXN_PARITY_EN
    check("lit_par_a5", 32'(dout_par), 32'h0);
`endif

    // Out-of-range selects, including exactly N
    req(3'd5);
    check("lit_err", 32'(sel_err), 32'h1);
    check("lit_err_cur", 32'(sel_cur), 32'h2);
    check("lit_err_vld", 32'(dout_vld), 32'h1);
    tick();
    check("lit_err_pulse", 32'(sel_err), 32'h0);
    req(3'd7);
    tick();

    // 2 -> 1, then 1 -> 1 no-op
    req(3'd1);
    tick(G + 2);
    check("lit_ch1", 32'(dout), 32'h22);
    req(3'd1);
    check("lit_noop_busy", 32'(busy), 32'h0);
    check("lit_noop_vld", 32'(dout_vld), 32'h1);
    check("lit_noop_rdy", 32'(sel_rdy), 32'h1);

    // Held request: 3 accepted, then 4 held through the sequence
    sel_req = 3'd3;
    sel_vld = 1'b1;
    tick();
    sel_req = 3'd4;
    din[15:8] = 8'h99;
    tick(G + 1);
    check("lit_held_cur3", 32'(sel_cur), 32'h3);
    tick();
    sel_vld = 1'b0;
    check("lit_held_busy", 32'(busy), 32'h1);
    tick(G + 1);
    check("lit_held_cur4", 32'(sel_cur), 32'h4);
    tick();
    check("lit_ch4", 32'(dout), 32'h3C);

    // 4 -> 3 to show parity of 0x07
    req(3'd3);
    tick(G + 2);
    check("lit_ch3", 32'(dout), 32'h07);
`ifdef CHIPLIB_MUXN_PARITY_EN
    check("lit_par_07", 32'(dout_par), 32'h1);
`endif

    // Reset in the middle of HOLD
    req(3'd2);
    #2 rst = 1'b1;
    #1;
    check("lit_abort_cur", 32'(sel_cur), 32'h0);
    check("lit_abort_dout", 32'(dout), 32'h00);
    check("lit_abort_busy", 32'(busy), 32'h0);
    tick(2);
    rst = 1'b0;
    tick();
    check("lit_after_dout", 32'(dout), 32'h5A);
    check("lit_after_cur", 32'(sel_cur), 32'h0);
    tick(3);

    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
